ex_alu_pipe: RTL and testbench

EX_ALU_PIPE -- requirements
Module: ex_alu_pipe

---
 rtl/ex_alu_pipe_pkg.sv | 38 +++
 rtl/iterative_multiplier.sv | 50 +++++
 rtl/ex_alu_pipe.sv | 82 ++++++++
 tb/tb_ex_alu_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_pipe_pkg.sv
// Shared EX-stage definitions: ALU operation codes, EX FSM states, multiplier step count.
package ex_alu_pipe_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam int         MUL_CNT_W = 7;
  localparam logic [6:0] MUL_STEPS = 7'd64;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Unlisted codes fall back to AND; ADD/SUB wrap modulo 2^64.
  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0]      ctrl,
                                                  input logic [XLEN-1:0] op_a,
                                                  input logic [XLEN-1:0] op_b);
    logic [XLEN-1:0] r;
    case (ctrl)
      ALU_ORR:  r = op_a | op_b;
      ALU_ADD:  r = op_a + op_b;
      ALU_SUB:  r = op_a - op_b;
      ALU_PASS: r = op_b;
      ALU_NOR:  r = ~(op_a | op_b);
      default:  r = op_a & op_b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier: one step per cycle, done pulses for one cycle after MUL_STEPS steps.
// Abort/reset clear the counter and drop the operation in progress.
module iterative_multiplier
  import ex_alu_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0]      mcand;
  logic [XLEN-1:0]      mplier;
  logic [XLEN-1:0]      acc;
  logic [MUL_CNT_W-1:0] cnt;
  logic                 busy;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt == MUL_STEPS) begin
        busy <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 7'd1;
      end
    end
  end

  assign done    = busy && (cnt == MUL_STEPS);
  assign product = acc;

endmodule

// File: rtl/ex_alu_pipe.sv
// EX-stage ALU with a registered result: single-cycle ops in 1 cycle, MUL in 65 cycles.
// Holds the result while downstream stalls; flush drops registered and in-flight work.
module ex_alu_pipe
  import ex_alu_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e          state_q;
  state_e          state_d;
  logic            accept;
  logic            is_mul;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic [XLEN-1:0] alu_res;

  assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul    = (alu_control == ALU_MUL);
  assign mul_start = accept && is_mul;
  assign alu_res   = alu_compute(alu_control, a, b);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Priority: flush, then new single-cycle result, then MUL completion, then drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      result    <= alu_res;
      zero      <= (alu_res == '0);
      out_valid <= 1'b1;
    end else if ((state_q == MUL) && mul_done) begin
      result    <= mul_product;
      zero      <= (mul_product == '0);
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  iterative_multiplier u_mul (
    .clk     (clk),
    .reset   (reset),
    .abort   (flush),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_ex_alu_pipe.sv
// Directed bench for ex_alu_pipe: expected results queued at issue, checked by a monitor on transfer.
module tb_ex_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;

  typedef struct {
    logic [63:0] res;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  ex_alu_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] va, input logic [63:0] vb,
                       input bit push, input logic [63:0] er, input logic ez);
    exp_t e;
    alu_control = op;
    a           = va;
    b           = vb;
    in_valid    = 1'b1;
    check("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
    if (push) begin
      e.res = er;
      e.z   = ez;
      exp_q.push_back(e);
    end
    tick();
    in_valid    = 1'b0;
    alu_control = 4'hX;
    a           = 'x;
    b           = 'x;
  endtask

  // Monitor: every transfer (out_valid && out_ready) is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", result, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("zero", {63'd0, zero}, {63'd0, e.z});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Back-to-back single-cycle ops, then drain with no new op.
    issue(4'b0010, 64'd5, 64'd7, 1, 64'd12, 1'b0);
    issue(4'b0110, 64'd3, 64'd3, 1, 64'd0, 1'b1);
    check("b2b_second_valid", {63'd0, out_valid}, 64'd1);
    tick();
    check("drain_clears_valid", {63'd0, out_valid}, 64'd0);

    // Wraparound, default decode, OR.
    issue(4'b0010, ONES, 64'd1, 1, 64'd0, 1'b1);
    issue(4'b0110, 64'd0, 64'd1, 1, ONES, 1'b0);
    issue(4'b1111, 64'hF0, 64'h3C, 1, 64'h30, 1'b0);
    issue(4'b0001, 64'hF0, 64'h0F, 1, 64'hFF, 1'b0);
    tick();

    // Stall: NOR result held while downstream is not ready; a competing offer is ignored.
    out_ready = 1'b0;
    issue(4'b1100, 64'd0, 64'd0, 1, ONES, 1'b0);
    in_valid = 1'b1; alu_control = 4'b0010; a = 64'd1; b = 64'd1;
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_result", result, ONES);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_released", {63'd0, out_valid}, 64'd0);

    // MUL: in_ready low while iterating, result lands 65 cycles after acceptance.
    issue(4'b1000, 64'd123456789, 64'd1000, 1, 64'd123456789000, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      check("mul_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("mul_out_valid_low", {63'd0, out_valid}, 64'd0);
      tick();
    end
    check("mul_cycle64_not_done", {63'd0, out_valid}, 64'd0);
    tick();
    check("mul_cycle65_valid", {63'd0, out_valid}, 64'd1);
    tick();

    // Flush during MUL at cycle 10.
    issue(4'b1000, 64'd7, 64'd9, 0, 64'd0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mul_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_mul_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    check("flushed_mul_no_result", {63'd0, seen}, 64'd0);
    issue(4'b0111, 64'd5, 64'd0, 1, 64'd0, 1'b1);
    tick();

    // Flush drops a registered result and wins over a simultaneous offer.
    out_ready = 1'b0;
    issue(4'b0010, 64'd1, 64'd1, 0, 64'd0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; alu_control = 4'b0010; a = 64'd2; b = 64'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_drops_result", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;

    // Reset (with flush) abandons a MUL in progress.
    issue(4'b0010, 64'd2, 64'd3, 1, 64'd5, 1'b0);
    tick();
    issue(4'b1000, 64'd3, 64'd4, 0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst2_result", result, 64'd0);
    check("rst2_zero", {63'd0, zero}, 64'd0);
    check("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    check("reset_mul_no_result", {63'd0, seen}, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
